// File: rtl/divide_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package divide_arb_pkg;

   localparam int unsigned F32_WIDTH = 32;
   localparam logic [F32_WIDTH-1:0] F32_QNAN = 32'h7fc00000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Operand pair presented to the divider.
   typedef struct packed {
      logic [F32_WIDTH-1:0] num;
      logic [F32_WIDTH-1:0] den;
   } div_ops_t;

endpackage

// File: rtl/divide_arbiter_f32_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, with wraparound.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   logic [IDX_W-1:0] idx;

   // Scan from the farthest offset down so the offset nearest ptr wins last.
   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(ptr) + k) % int'(N));
         if (req[idx]) begin
            any       = 1'b1;
            grant_idx = idx;
         end
      end
      grant = '0;
      if (any) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/divide_arbiter_f32.sv
// Shares one iterative f32 divider between N_REQ requesters.
module divide_arbiter_f32
   import divide_arb_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 32,
   localparam int unsigned ID_W   = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [32*N_REQ-1:0]   req_num,
   input  logic [32*N_REQ-1:0]   req_den,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  resp_valid,
   output logic [ID_W-1:0]       resp_id,
   output logic [31:0]           resp_quo,
   output logic                  resp_timeout,
   input  logic                  resp_ready,
   output logic                  div_rst,
   output logic [31:0]           div_num,
   output logic [31:0]           div_den,
   input  logic                  div_rdy,
   input  logic [31:0]           div_quo
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

   state_t           state, state_next;
   logic [ID_W-1:0]  ptr, ptr_next, id_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [31:0]      quo_next;
   logic             tmo_next;
   div_ops_t         ops, ops_next;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             any;
   logic [31:0]      num_arr [N_REQ];
   logic [31:0]      den_arr [N_REQ];

   // Unpack the flat operand buses per requester.
   for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
      assign num_arr[i] = req_num[F32_WIDTH*i +: F32_WIDTH];
      assign den_arr[i] = req_den[F32_WIDTH*i +: F32_WIDTH];
   end

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   assign div_num = ops.num;
   assign div_den = ops.den;

   // Accept pulse only in the IDLE cycle that takes the grant.
   always_comb begin
      req_ready = '0;
      if (state == IDLE) req_ready = grant;
   end

   // Next-state and next-value logic.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      cnt_next   = cnt;
      id_next    = resp_id;
      quo_next   = resp_quo;
      tmo_next   = resp_timeout;
      ops_next   = ops;
      case (state)
         IDLE: begin
            if (any) begin
               state_next   = LAUNCH;
               ptr_next     = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
               id_next      = grant_idx;
               ops_next.num = num_arr[grant_idx];
               ops_next.den = den_arr[grant_idx];
            end
         end
         LAUNCH: begin
            state_next = WAIT;
            cnt_next   = '0;
         end
         WAIT: begin
            if (div_rdy) begin
               state_next = RESP;
               quo_next   = div_quo;
               tmo_next   = 1'b0;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               state_next = RESP;
               quo_next   = F32_QNAN;
               tmo_next   = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State and output registers; divider is held in reset outside WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         cnt          <= '0;
         ops          <= '0;
         resp_valid   <= 1'b0;
         resp_id      <= '0;
         resp_quo     <= '0;
         resp_timeout <= 1'b0;
         div_rst      <= 1'b1;
      end else begin
         state        <= state_next;
         ptr          <= ptr_next;
         cnt          <= cnt_next;
         ops          <= ops_next;
         resp_valid   <= (state_next == RESP);
         resp_id      <= id_next;
         resp_quo     <= quo_next;
         resp_timeout <= tmo_next;
         div_rst      <= (state_next != WAIT);
      end
   end

endmodule

// File: tb/tb_divide_arbiter_f32.sv
// Directed bench for divide_arbiter_f32 with a stub divider and a response scoreboard.
module tb_divide_arbiter_f32;
   import divide_arb_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [127:0] req_num = '0;
   logic [127:0] req_den = '0;
   logic [3:0]   req_ready;
   logic         resp_valid;
   logic [1:0]   resp_id;
   logic [31:0]  resp_quo;
   logic         resp_timeout;
   logic         resp_ready = 1'b0;
   logic         div_rst;
   logic [31:0]  div_num, div_den;
   logic         div_rdy;
   logic [31:0]  div_quo;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] quo;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int hs_count = 0;
   int exp_count = 0;

   // Stub divider: ready stub_lat+1 cycles after release, or never when hung.
   int   stub_lat = 3;
   bit   stub_hang = 1'b0;
   int   dcnt = 0;
   logic rdy = 1'b0;

   function automatic logic [31:0] ref_div(input logic [31:0] n, input logic [31:0] d);
      case ({n, d})
         {32'h40c00000, 32'h40400000}: return 32'h40000000;
         {32'h40800000, 32'h40000000}: return 32'h40000000;
         {32'h41000000, 32'h40000000}: return 32'h40800000;
         {32'h41400000, 32'h40000000}: return 32'h40c00000;
         {32'h41800000, 32'h40000000}: return 32'h41000000;
         {32'h3f800000, 32'h00000000}: return 32'h7f800000;
         default:                      return n ^ d ^ 32'h00ff00ff;
      endcase
   endfunction

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (div_rst === 1'b1) begin
         dcnt <= 0;
         rdy  <= 1'b0;
      end else if (!stub_hang && !rdy) begin
         if (dcnt == stub_lat) rdy <= 1'b1;
         else dcnt <= dcnt + 1;
      end
   end

   assign div_rdy = rdy;
   assign div_quo = rdy ? ref_div(div_num, div_den) : 32'hdeadbeef;

   // Count completed response handshakes.
   always @(posedge clk) begin
      if (rst === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) hs_count <= hs_count + 1;
   end

   divide_arbiter_f32 #(.N_REQ(4), .TIMEOUT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_num      (req_num),
      .req_den      (req_den),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_id      (resp_id),
      .resp_quo     (resp_quo),
      .resp_timeout (resp_timeout),
      .resp_ready   (resp_ready),
      .div_rst      (div_rst),
      .div_num      (div_num),
      .div_den      (div_den),
      .div_rdy      (div_rdy),
      .div_quo      (div_quo)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [31:0] n, input logic [31:0] d);
      req_num[32*i +: 32] = n;
      req_den[32*i +: 32] = d;
   endtask

   task automatic push_exp(input int i, input logic [31:0] n, input logic [31:0] d);
      sb.push_back('{id: 2'(i), quo: ref_div(n, d), tmo: 1'b0});
      exp_count++;
   endtask

   // Check the accept pulse at a negedge, then let the grant edge happen.
   task automatic grant_step(input string tag, input logic [3:0] exp_mask);
      #1;
      chk(tag, 32'(req_ready), 32'(exp_mask));
      @(posedge clk);
   endtask

   // Wait for a response, compare with the scoreboard, optionally stall, then accept.
   task automatic expect_resp(input string tag, input int n0, input int lat, input int hold,
                              input logic [3:0] valid_after, input logic [3:0] valid_end);
      int   n;
      exp_t e;
      n = n0;
      do begin
         @(negedge clk);
         n++;
         if (n == n0 + 1) req_valid = valid_after;
      end while (resp_valid !== 1'b1 && n < 40);
      chk({tag, " valid"}, 32'(resp_valid), 32'd1);
      if (lat > 0) chk({tag, " latency"}, 32'(n), 32'(lat));
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL %s scoreboard observed empty expected entry", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, " id"}, 32'(resp_id), 32'(e.id));
      chk({tag, " quo"}, resp_quo, e.quo);
      chk({tag, " timeout"}, 32'(resp_timeout), 32'(e.tmo));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
         chk({tag, " hold id"}, 32'(resp_id), 32'(e.id));
         chk({tag, " hold quo"}, resp_quo, e.quo);
         chk({tag, " hold timeout"}, 32'(resp_timeout), 32'(e.tmo));
         chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid  = valid_end;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, " idle after"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      int order[5];
      bit seen;
      order = '{0, 1, 2, 3, 0};

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_id", 32'(resp_id), 32'd0);
      chk("rst resp_quo", resp_quo, 32'd0);
      chk("rst resp_timeout", 32'(resp_timeout), 32'd0);
      chk("rst div_rst", 32'(div_rst), 32'd1);
      chk("rst div_num", div_num, 32'd0);
      chk("rst div_den", div_den, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single divide 6.0 / 3.0 with div_rst pulse check
      set_ops(0, 32'h40c00000, 32'h40400000);
      req_valid = 4'b0001;
      push_exp(0, 32'h40c00000, 32'h40400000);
      grant_step("single grant", 4'b0001);
      @(negedge clk);
      req_valid = 4'b0000;
      chk("single launch div_rst", 32'(div_rst), 32'd1);
      chk("single div_num", div_num, 32'h40c00000);
      chk("single div_den", div_den, 32'h40400000);
      chk("single launch req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("single wait div_rst", 32'(div_rst), 32'd0);
      @(negedge clk);
      chk("single wait2 div_rst", 32'(div_rst), 32'd0);
      expect_resp("single", 3, 7, 0, 4'b0000, 4'b0000);

      // Round robin from ptr=0 with all requesters valid
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_ops(0, 32'h40800000, 32'h40000000);
      set_ops(1, 32'h41000000, 32'h40000000);
      set_ops(2, 32'h41400000, 32'h40000000);
      set_ops(3, 32'h41800000, 32'h40000000);
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         push_exp(order[i], req_num[32*order[i] +: 32], 32'h40000000);
         grant_step("rr grant", 4'(1 << order[i]));
         if (i < 4) expect_resp("rr", 0, 7, 0, 4'b1111, 4'b1111);
         else       expect_resp("rr", 0, 7, 0, 4'b0000, 4'b0000);
      end
      // ptr=1: grant 1 alone moves ptr to 2, then 1 and 3 compete
      req_valid = 4'b0010;
      push_exp(1, 32'h41000000, 32'h40000000);
      grant_step("rr set ptr", 4'b0010);
      expect_resp("rr set ptr", 0, 7, 0, 4'b1010, 4'b1010);
      push_exp(3, 32'h41800000, 32'h40000000);
      grant_step("rr ptr2 grant3", 4'b1000);
      expect_resp("rr ptr2 resp3", 0, 7, 0, 4'b1010, 4'b1010);
      push_exp(1, 32'h41000000, 32'h40000000);
      grant_step("rr then grant1", 4'b0010);
      expect_resp("rr resp1", 0, 7, 0, 4'b0000, 4'b0000);

      // Timeout with a hung divider (ptr=2)
      stub_hang = 1'b1;
      set_ops(2, 32'h3f800000, 32'h40400000);
      req_valid = 4'b0100;
      sb.push_back('{id: 2'd2, quo: 32'h7fc00000, tmo: 1'b1});
      exp_count++;
      grant_step("timeout grant", 4'b0100);
      expect_resp("timeout", 0, 10, 0, 4'b0000, 4'b0000);
      stub_hang = 1'b0;

      // div_rdy in the same cycle the counter expires (ptr=3)
      stub_lat = 6;
      set_ops(3, 32'h41000000, 32'h40000000);
      req_valid = 4'b1000;
      push_exp(3, 32'h41000000, 32'h40000000);
      grant_step("race grant", 4'b1000);
      expect_resp("race", 0, 10, 0, 4'b0000, 4'b0000);
      stub_lat = 3;

      // Backpressure with other requesters waiting (ptr=0)
      set_ops(0, 32'h40c00000, 32'h40400000);
      req_valid = 4'b0001;
      push_exp(0, 32'h40c00000, 32'h40400000);
      grant_step("bp grant", 4'b0001);
      expect_resp("bp", 0, 7, 5, 4'b1110, 4'b0000);

      // Reset during WAIT drops the request (ptr=1)
      set_ops(1, 32'h40800000, 32'h40000000);
      req_valid = 4'b0010;
      grant_step("mid grant", 4'b0010);
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      chk("mid in wait div_rst", 32'(div_rst), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid state", 32'(dut.state), 32'(IDLE));
      chk("mid div_rst", 32'(div_rst), 32'd1);
      chk("mid resp_valid", 32'(resp_valid), 32'd0);
      chk("mid div_num", div_num, 32'd0);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) seen = 1'b1;
      end
      chk("mid no response", 32'(seen), 32'd0);

      // Zero denominator forwarded as returned (ptr=0)
      set_ops(3, 32'h3f800000, 32'h00000000);
      req_valid = 4'b1000;
      push_exp(3, 32'h3f800000, 32'h00000000);
      grant_step("zden grant", 4'b1000);
      expect_resp("zden", 0, 7, 0, 4'b0000, 4'b0000);

      repeat (3) @(negedge clk);
      chk("handshake count", 32'(hs_count), 32'(exp_count));
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/divide_arbiter_f32.md
# divide_arbiter_f32

Shares one iterative `divide_f32` unit (Newton-Raphson reciprocal times multiply) between `N_REQ` processing-element requesters. Round-robin arbitration picks a request, latches its operands, and restarts the divider. The block waits for the divider's ready flag, bounded by a cycle timeout, then returns the quotient tagged with the requester id. It sits between the PE array and the single divider instance in the PE datapath.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `TIMEOUT`, 32: maximum WAIT cycles before the block abandons a division.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester request.
- `req_num` in 32*N_REQ: numerator floats; requester i uses bits [32i+31:32i].
- `req_den` in 32*N_REQ: denominator floats, same packing.
- `req_ready` out N_REQ: one-hot accept pulse.
- `resp_valid` out 1: response available.
- `resp_id` out $clog2(N_REQ): requester the response belongs to.
- `resp_quo` out 32: quotient float.
- `resp_timeout` out 1: response was produced by timeout.
- `resp_ready` in 1: consumer accepts the response.
- `div_rst` out 1: restart pulse to the divider's `rst`. Registered.
- `div_num`, `div_den` out 32: operands to the divider. Registered.
- `div_rdy` in 1: divider ready.
- `div_quo` in 32: divider quotient.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid`, grant requester g → LAUNCH.
  - LAUNCH: → WAIT.
  - WAIT: on `div_rdy` → RESP. If `div_rdy` is low and cnt == TIMEOUT-1 → RESP with the timeout flag set.
  - RESP: on `resp_ready` → IDLE.
- Arbitration:
  - Round-robin search starting at pointer `ptr`.
  - g is the first index i, counting from `ptr` with wraparound, where `req_valid[i]` is high.
  - `req_ready[g]`=1 only in the IDLE cycle where the grant is taken. This is combinational from state, `req_valid` and `ptr`.
  - On grant: `ptr` ← (g+1) mod N_REQ, `resp_id` ← g.
- Operand capture: in the grant cycle, `div_num`/`div_den` ← requester g's operands. They are held unchanged through LAUNCH, WAIT and RESP, because the divider reads them combinationally every iteration.
- `div_rst` is 1 while in LAUNCH and 0 in WAIT. It is 1 during reset and in IDLE, which parks the divider.
- `div_rdy` is sampled only in WAIT and ignored elsewhere.
- Cycle counter `cnt`: cleared on entering WAIT, increments each WAIT cycle. Width is $clog2(TIMEOUT)+1.
- Normal completion: `resp_quo` ← `div_quo` and `resp_timeout` ← 0, captured in the WAIT cycle where `div_rdy`=1.
- Timeout: `resp_quo` ← 32'h7fc00000 (quiet NaN) and `resp_timeout` ← 1.
- Zero denominator: no special-casing. The divider result is forwarded as returned.
- `resp_valid`=1 throughout RESP. `resp_id`, `resp_quo` and `resp_timeout` stay stable until the handshake completes.
- Requests arriving while the block is busy wait. No queueing; `req_ready` stays 0.

## Timing
- Reset values:
  - State IDLE, `ptr`=0.
  - `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_quo`=0, `resp_timeout`=0.
  - `div_rst`=1, `div_num`=0, `div_den`=0, `cnt`=0.
- Reset mid-operation: the in-flight division is dropped with no response, and all outputs take their reset values on the next edge.
- Latency from grant edge (cycle 0) to `resp_valid`:
  - LAUNCH at cycle 1, WAIT from cycle 2.
  - `resp_valid` rises at cycle 2+k+1, where k is the number of WAIT cycles before `div_rdy`.
  - Worst case is cycle 2+TIMEOUT.
- `resp_ready` high in the first RESP cycle gives IDLE in the next cycle. A new grant is possible in that same IDLE cycle.
- Throughput: at most one division in flight. The minimum gap between grants is 4 cycles.
- Simultaneous `div_rdy` and timeout in the same cycle: `div_rdy` wins and `resp_timeout`=0.

## Structure
- Package `divide_arb_pkg` holds:
  - state enum (IDLE, LAUNCH, WAIT, RESP);
  - `F32_QNAN` = 32'h7fc00000;
  - `F32_WIDTH` = 32.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs `req`, `ptr`;
  - outputs `grant` (one-hot), `grant_idx`, `any`.
- The divider is instantiated outside this block and connected through the `div_*` ports.

## Test plan
- Single divide: requester 0 sends num 0x40c00000 (6.0), den 0x40400000 (3.0). Required response: `resp_id`=0, `resp_quo` within 2 ULP of 0x40000000, `resp_timeout`=0, and the `div_rst` pulse is exactly 1 cycle.
- Round robin: all 4 requesters held valid, each with den 0x40000000. Required grant order: 0,1,2,3,0. After `ptr`=2 is set, a request from 1 and 3 grants 3 first.
- Timeout: stub divider that never asserts `div_rdy`, TIMEOUT=8. Required: `resp_valid` at cycle 10 after the grant, `resp_quo`=0x7fc00000, `resp_timeout`=1.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP. Required: outputs stable, `req_ready` stays 0, and exactly one response.
- Mid-operation reset: assert `rst` during WAIT. Required: the next cycle shows IDLE, `div_rst`=1, `resp_valid`=0, and no response is ever issued for the dropped request.
- Zero denominator: num 0x3f800000, den 0x00000000. Required: the divider output is forwarded with `resp_timeout`=0.
